// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_supervisor
// Brief  : Qualifies the PLL lock flag and sequences the downstream reset,
//          counting loss-of-lock events.
// Rev    : 1.0
// ============================================================================
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 locked_in,
  input  logic                 count_clear,
  output logic                 reset_out,
  output logic                 ready,
  output logic                 lost_pulse,
  output logic [CNT_WIDTH-1:0] loss_count
);

  localparam int c_CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int c_CW      = $clog2(c_CNT_MAX) + 1;
  localparam logic [c_CW-1:0] c_STABLE_LAST = c_CW'(STABLE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST   = c_CW'(HOLD_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_ONE     = c_CW'(1);

  typedef enum logic [1:0] {
    S_WAIT      = 2'd0,
    S_STABILIZE = 2'd1,
    S_RUN       = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_s1;
  logic                 r_locked_s;
  logic [c_CW-1:0]      r_cnt;
  logic                 r_reset_out;
  logic                 r_ready;
  logic                 r_lost_pulse;
  logic [CNT_WIDTH-1:0] r_loss_count;
  logic                 w_loss_event;
  logic                 w_cnt_sat;

  assign w_loss_event = (r_state == S_RUN) && !r_locked_s;
  assign w_cnt_sat    = &r_loss_count;

  // Two-flop synchroniser; only r_locked_s is trusted downstream.
  always_ff @(posedge clk or posedge reset) begin : p_sync
    if (reset) begin
      r_s1       <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_s1       <= locked_in;
      r_locked_s <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_fsm
    if (reset) begin
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      r_reset_out  <= 1'b1;
      r_ready      <= 1'b0;
      r_lost_pulse <= 1'b0;
    end else begin
      r_lost_pulse <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (r_locked_s) begin
            r_state <= S_STABILIZE;
            r_cnt   <= c_CNT_ONE;
          end
        end
        S_STABILIZE: begin
          if (!r_locked_s) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else if (r_cnt == c_STABLE_LAST) begin
            r_state     <= S_RUN;
            r_reset_out <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        S_RUN: begin
          if (!r_locked_s) begin
            r_state      <= S_HOLD;
            r_cnt        <= c_CNT_ONE;
            r_reset_out  <= 1'b1;
            r_ready      <= 1'b0;
            r_lost_pulse <= 1'b1;
          end
        end
        S_HOLD: begin
          // Lock is deliberately ignored here so reset is held its full minimum time.
          if (r_cnt == c_HOLD_LAST) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // A loss coinciding with a clear must still be recorded, hence the load of 1.
  always_ff @(posedge clk or posedge reset) begin : p_loss_count
    if (reset) begin
      r_loss_count <= '0;
    end else if (w_loss_event) begin
      if (count_clear) begin
        r_loss_count <= CNT_WIDTH'(1);
      end else if (!w_cnt_sat) begin
        r_loss_count <= r_loss_count + CNT_WIDTH'(1);
      end
    end else if (count_clear) begin
      r_loss_count <= '0;
    end
  end

  assign reset_out  = r_reset_out;
  assign ready      = r_ready;
  assign lost_pulse = r_lost_pulse;
  assign loss_count = r_loss_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module : tb_pll_lock_supervisor
// Brief  : Change-log scoreboard bench for pll_lock_supervisor.
// Rev    : 1.0
// ============================================================================
module tb_pll_lock_supervisor;

  localparam int STABLE_CYCLES = 4;
  localparam int HOLD_CYCLES   = 3;
  localparam int CNT_WIDTH     = 2;

  logic                 clk;
  logic                 reset;
  logic                 locked_in;
  logic                 count_clear;
  logic                 reset_out;
  logic                 ready;
  logic                 lost_pulse;
  logic [CNT_WIDTH-1:0] loss_count;

  int tests;
  int errors;
  int cyc;
  int exp_cnt;

  // Each entry is the full output vector the DUT must show at the next sample
  // where any output differs from the previous sample, tagged with its cycle.
  typedef struct {
    int                   cyc;
    logic                 ro;
    logic                 rdy;
    logic                 lp;
    logic [CNT_WIDTH-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  pll_lock_supervisor #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .locked_in  (locked_in),
    .count_clear(count_clear),
    .reset_out  (reset_out),
    .ready      (ready),
    .lost_pulse (lost_pulse),
    .loss_count (loss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic ro, input logic rdy,
                      input logic lp, input int cnt);
    obs_t e;
    e.cyc = c;
    e.ro  = ro;
    e.rdy = rdy;
    e.lp  = lp;
    e.cnt = CNT_WIDTH'(cnt);
    exp_q.push_back(e);
  endtask

  // Drops lock for one cycle starting at the current negedge (cycle m);
  // the loss registers at m+3, the pulse ends at m+4, requalified at m+10.
  task automatic do_loss(input bit clr);
    int m;
    m = cyc;
    if (clr) exp_cnt = 1;
    else if (exp_cnt < 3) exp_cnt = exp_cnt + 1;
    push(m + 3, 1'b1, 1'b0, 1'b1, exp_cnt);
    push(m + 4, 1'b1, 1'b0, 1'b0, exp_cnt);
    push(m + 10, 1'b0, 1'b1, 1'b0, exp_cnt);
    locked_in = 1'b0;
    @(negedge clk);
    locked_in = 1'b1;
    @(negedge clk);
    if (clr) count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  initial begin : monitor
    obs_t o;
    obs_t e;
    bit   first;
    logic ro_p, rdy_p, lp_p;
    logic [CNT_WIDTH-1:0] cnt_p;
    first = 1'b1;
    ro_p = 1'b0; rdy_p = 1'b0; lp_p = 1'b0; cnt_p = '0;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (first || reset_out !== ro_p || ready !== rdy_p ||
          lost_pulse !== lp_p || loss_count !== cnt_p) begin
        first = 1'b0;
        o.cyc = cyc;
        o.ro  = reset_out;
        o.rdy = ready;
        o.lp  = lost_pulse;
        o.cnt = loss_count;
        tests = tests + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_change cyc=%0d got ro=%b rdy=%b lp=%b cnt=%0d, required no change",
                   o.cyc, o.ro, o.rdy, o.lp, o.cnt);
        end else begin
          e = exp_q.pop_front();
          if (o.cyc != e.cyc || o.ro !== e.ro || o.rdy !== e.rdy ||
              o.lp !== e.lp || o.cnt !== e.cnt) begin
            errors = errors + 1;
            $display("FAIL output_change got cyc=%0d ro=%b rdy=%b lp=%b cnt=%0d, required cyc=%0d ro=%b rdy=%b lp=%b cnt=%0d",
                     o.cyc, o.ro, o.rdy, o.lp, o.cnt, e.cyc, e.ro, e.rdy, e.lp, e.cnt);
          end
        end
      end
      ro_p  = reset_out;
      rdy_p = ready;
      lp_p  = lost_pulse;
      cnt_p = loss_count;
    end
  end

  initial begin : watchdog
    #200000;
    errors = errors + 1;
    $display("FAIL watchdog expired at cyc=%0d, required stimulus to complete", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin : stimulus
    int n;
    tests       = 0;
    errors      = 0;
    cyc         = 0;
    exp_cnt     = 0;
    reset       = 1'b0;
    locked_in   = 1'b0;
    count_clear = 1'b0;

    // Power-up reset state, then no lock for 20 cycles: nothing may change.
    push(0, 1'b1, 1'b0, 1'b0, 0);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Unstable lock: 3 high / 1 low never completes qualification.
    repeat (5) begin
      locked_in = 1'b1;
      repeat (3) @(negedge clk);
      locked_in = 1'b0;
      @(negedge clk);
    end

    // Steady lock: E0 is the next edge, release at E5.
    n = cyc;
    push(n + 6, 1'b0, 1'b1, 1'b0, 0);
    locked_in = 1'b1;
    repeat (10) @(negedge clk);

    // Four losses: count 1,2,3 then saturated at 3.
    do_loss(1'b0);
    do_loss(1'b0);
    do_loss(1'b0);
    do_loss(1'b0);

    // Clear on the same edge as a fifth loss keeps that loss.
    do_loss(1'b1);

    // Clear on its own.
    n = cyc;
    push(n + 1, 1'b0, 1'b1, 1'b0, 0);
    exp_cnt = 0;
    count_clear = 1'b1;
    @(negedge clk);
    count_clear = 1'b0;
    repeat (3) @(negedge clk);

    // Raise loss_count again so the async reset visibly clears it.
    do_loss(1'b0);

    // Async reset between edges: outputs must change before the next edge.
    @(posedge clk);
    #2;
    push(cyc, 1'b1, 1'b0, 1'b0, 0);
    exp_cnt = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n = cyc;
    push(n + 6, 1'b0, 1'b1, 1'b0, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    tests = tests + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL pending_expectations got %0d outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer end of the iCE40 PLL wrapper's `locked` output.
- Runs in the PLL output clock domain.
- Synchronises the raw asynchronous lock flag and releases a system reset only after lock has been continuously stable for a set time.
- Re-asserts reset on loss of lock, holds it for a minimum time, and keeps a saturating loss-of-lock event counter that host peripherals can read.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before reset release. Legal range is 2 or more.
- HOLD_CYCLES, 16: minimum cycles reset stays asserted after a loss of lock. Legal range is 1 or more.
- CNT_WIDTH, 8: width of loss_count.

Ports:
- clk  input  1  PLL output clock; all logic runs on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- locked_in  input  1  raw PLL lock flag, asynchronous to clk.
- count_clear  input  1  synchronous; zeroes loss_count.
- reset_out  output  1  active-high system reset for downstream logic.
- ready  output  1  high while in RUN.
- lost_pulse  output  1  one-cycle pulse on each loss of lock detected in RUN.
- loss_count  output  CNT_WIDTH  saturating count of loss events.

Behaviour:
- Reset values, applied asynchronously while reset=1:
  - reset_out=1, ready=0, lost_pulse=0, loss_count=0
  - both sync flops=0, state=WAIT, cycle counter=0
- Reset de-assertion is handled synchronously: all outputs are registered, and reset_out can only fall on a clk edge.
- Synchroniser: two flops, locked_in -> s1 -> locked_s. Only locked_s is used internally.
- One internal counter, width clog2(max(STABLE_CYCLES, HOLD_CYCLES)) + 1, shared by the STABILIZE and HOLD states.
- State WAIT:
  - reset_out=1, ready=0.
  - If locked_s=1: go to STABILIZE, cnt<=1.
- State STABILIZE:
  - reset_out=1.
  - If locked_s=0: go to WAIT, cnt<=0. This is not a loss event and lost_pulse stays 0.
  - Else if cnt==STABLE_CYCLES-1: go to RUN; reset_out<=0 and ready<=1 on the same edge.
  - Else cnt<=cnt+1.
- State RUN:
  - reset_out=0, ready=1.
  - If locked_s=0, on the same edge: go to HOLD, cnt<=1, reset_out<=1, ready<=0, lost_pulse<=1, and loss_count increments (saturating).
- State HOLD:
  - reset_out=1. locked_in is ignored.
  - If cnt==HOLD_CYCLES: go to WAIT, else cnt<=cnt+1.
  - Total time in HOLD is exactly HOLD_CYCLES cycles.
- lost_pulse is high for exactly one cycle per RUN->HOLD transition, otherwise 0.
- Release latency: let E0 be the first edge that captures locked_in=1 into s1, with locked_in then held high. reset_out falls at edge E(STABLE_CYCLES+1).
- Loss latency: reset_out rises at the edge E2 after the first edge that captures locked_in=0.
- loss_count:
  - Saturates at 2^CNT_WIDTH-1; further losses leave it unchanged while lost_pulse still fires.
  - count_clear=1 zeroes it on the next edge.
  - If count_clear and a loss event occur on the same edge, the result is 1: the loss is not dropped.
- Glitch on locked_in shorter than one clk period may or may not be captured. Whatever locked_s shows is obeyed.
- Reset mid-operation, in any state: immediate return to reset values; loss_count is cleared.

Test Plan (bench overrides STABLE_CYCLES=4, HOLD_CYCLES=3, CNT_WIDTH=2):
- Power-up: reset=1 for 3 cycles with locked_in=0 -> reset_out=1, ready=0, loss_count=0. After release with locked_in=0 for 20 cycles -> reset_out stays 1.
- Clean lock: raise locked_in before edge E0 -> reset_out falls and ready rises exactly at E5, lost_pulse never high.
- Unstable lock: locked_in high for 3 cycles then low 1 cycle, repeated 5 times -> reset_out never falls, loss_count=0, lost_pulse=0. Then hold locked_in high -> release 5 edges after capture.
- Loss in RUN: drop locked_in for 1 cycle -> reset_out rises 2 edges after capture, lost_pulse high 1 cycle, loss_count=1. reset_out stays 1 for 3 cycles in HOLD, then requalification of 4 cycles before falling again.
- Saturation and clear: 4 loss events -> loss_count=3 (saturated), 4 lost_pulses seen. Assert count_clear on the same edge as a 5th loss -> loss_count=1. count_clear alone -> 0.
- Async reset mid-RUN: assert reset between edges -> reset_out=1 and loss_count=0 immediately, without waiting for a clk edge.
